freespace_credit_arbiter: RTL and testbench
===========================================

Name: freespace_credit_arbiter

Overview:
- Shares the single leaf-to-network injection path between the NUM_IN_PORTS input ports of a leaf interface.
- Each input port pulses freespace_update when it has freed a block of BRAM space. This block queues those requests per port and selects one port at a time, round-robin.
- It emits that port's freespace/credit packet, as presented on packet_from_input_ports, to the leaf output stream under a valid/ready handshake.
- It also reports back-pressure stalls for done-mode diagnostics.

Parameters:
- PACKET_BITS, 97, width of one network packet.
- NUM_IN_PORTS, 7, number of input ports arbitrated.
- PORT_IDX_BITS, 3, width of a port index; must satisfy 2**PORT_IDX_BITS >= NUM_IN_PORTS.
- CNT_BITS, 4, width of each per-port pending-request counter.
- STALL_LIMIT, 16, consecutive back-pressured cycles before stall_condition asserts.

Ports:
- clk  in  1  single clock (network clock domain).
- reset  in  1  asynchronous, active-low reset.
- freespace_update  in  NUM_IN_PORTS  one-cycle request pulse per port.
- packet_from_input_ports  in  PACKET_BITS*NUM_IN_PORTS  credit packet per port; port i occupies bits [PACKET_BITS*(i+1)-1 : PACKET_BITS*i].
- pkt_out  out  PACKET_BITS  registered packet toward the network.
- pkt_out_vld  out  1  pkt_out holds a valid packet.
- pkt_out_rdy  in  1  downstream accepts pkt_out this cycle.
- grant_idx  out  PORT_IDX_BITS  index of the port whose packet is on pkt_out.
- pending  out  NUM_IN_PORTS  bit i = counter i nonzero.
- overflow  out  NUM_IN_PORTS  sticky; a request was lost on port i.
- stall_condition  out  1  back-pressure lasted STALL_LIMIT cycles or more.

Behaviour:
- Reset (reset=0, asynchronous): counters=0, rr_ptr=0, state=IDLE, pkt_out=0, pkt_out_vld=0, grant_idx=0, overflow=0, stall counter=0, stall_condition=0.
- Per-port counter, updated at the clock edge:
  - +1 on a freespace_update pulse.
  - -1 when that port's packet handshakes (pkt_out_vld & pkt_out_rdy and grant_idx==i).
  - Both in the same cycle: value unchanged.
  - Increment at all-ones: counter holds all-ones and overflow[i] sets; it clears only on reset.
- Selection:
  - Combinational round-robin over ports whose counter is nonzero after this cycle's decrement; search starts at rr_ptr and wraps from NUM_IN_PORTS-1 to 0.
  - A pulse arriving this cycle is not eligible until the next cycle.
- FSM, two states:
  - IDLE: if any port is eligible, load pkt_out with the winner's slice, set grant_idx=winner and pkt_out_vld=1, set rr_ptr=winner+1 (wrapping), go to SEND. Otherwise stay in IDLE with pkt_out_vld=0.
  - SEND: pkt_out and grant_idx stay frozen while pkt_out_rdy=0.
  - SEND, on handshake with an eligible port remaining: load the next winner in the same cycle; pkt_out_vld stays 1, giving one packet per cycle.
  - SEND, on handshake with no eligible port: pkt_out_vld=0, go to IDLE.
- Latency: pulse at cycle t → counter nonzero at t+1 → pkt_out_vld=1 at t+2 if the block is idle.
- Packet sampling: the packet is sampled at load time. The source port holds its slice stable until its request is served.
- pending is a registered copy of counter-nonzero.
- Stall counter:
  - Increments in any cycle with pkt_out_vld & ~pkt_out_rdy, saturating at STALL_LIMIT.
  - Clears to 0 on a handshake or when pkt_out_vld=0.
  - stall_condition = (stall counter == STALL_LIMIT), registered.
- Reset mid-transfer: pkt_out_vld drops immediately and all queued requests are discarded.

Decomposition:
- Shared package:
  - Packet width constant.
  - Port-index width.
  - Function rr_pick(mask, ptr) returning {found, idx}.
- Natural sub-module: rr_arbiter (mask + pointer → one-hot grant and index), reusable by the output-port cluster.
- Counters, FSM and stall logic stay in this block.

Test Plan:
- Reset then idle: freespace_update=0 for 20 cycles → pkt_out_vld=0, pending=0, stall_condition=0 throughout.
- Single request:
  - Stimulus: port 3 pulses at cycle 5, slice 3 = 97'h1_0000_0003, pkt_out_rdy=1.
  - Response: pkt_out_vld=1 at cycle 7 with pkt_out=97'h1_0000_0003 and grant_idx=3; pkt_out_vld=0 at cycle 8.
- Simultaneous pulses:
  - Stimulus: ports 0, 3 and 6 pulse at the same cycle; rr_ptr=4; rdy=1.
  - Response: grants 6, 0, 3 on consecutive cycles with no bubbles, then pending=0.
- Back-pressure:
  - Stimulus: port 1 request with rdy=0 for 20 cycles.
  - Response: pkt_out stable; stall_condition=1 from the 16th stalled cycle onward. When rdy=1, one handshake, then stall_condition=0.
- Saturation:
  - Stimulus: port 2 pulses 17 times with rdy=0.
  - Response: counter=15 and overflow[2]=1. After rdy=1, exactly 15 port-2 packets are emitted.
- Async reset mid-SEND:
  - Stimulus: reset=0 while pkt_out_vld=1 with 3 requests queued.
  - Response: pkt_out_vld=0 before the next clock edge and pending=0. After release, no packets are emitted.

Source files
------------

// File: rtl/freespace_credit_arbiter_pkg.sv
// Shared types and helpers for the leaf freespace/credit injection arbiter.
// rr_pick is also used by the output-port cluster arbiters.
package freespace_credit_arbiter_pkg;

  localparam int PACKET_BITS_C    = 97;
  localparam int PORT_IDX_BITS_C  = 3;
  localparam int MAX_PORTS_C      = 2 ** PORT_IDX_BITS_C;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  typedef struct packed {
    logic                       found;
    logic [PORT_IDX_BITS_C-1:0] idx;
  } pick_t;

  // The search runs over the full index space. When ptr is below the real port
  // count and the unused mask bits are zero, this gives the same order as
  // wrapping at the real port count.
  function automatic pick_t rr_pick(input logic [MAX_PORTS_C-1:0]     mask,
                                    input logic [PORT_IDX_BITS_C-1:0] ptr);
    pick_t                      res;
    logic [PORT_IDX_BITS_C-1:0] cand;
    res.found = 1'b0;
    res.idx   = {PORT_IDX_BITS_C{1'b0}};
    for (int k = 0; k < MAX_PORTS_C; k++) begin
      cand = ptr + k[PORT_IDX_BITS_C-1:0];
      if (!res.found && mask[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/freespace_credit_arbiter_rr_arbiter.sv
// Round-robin picker: request mask plus start pointer gives a one-hot grant and an index.
// Valid for up to 2**PORT_IDX_BITS_C requesters.
module rr_arbiter
  import freespace_credit_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 7
) (
  input  logic [NUM_PORTS-1:0]       mask,
  input  logic [PORT_IDX_BITS_C-1:0] ptr,
  output logic                       found,
  output logic [PORT_IDX_BITS_C-1:0] idx,
  output logic [NUM_PORTS-1:0]       grant
);

  logic [MAX_PORTS_C-1:0] mask_ext_s;
  pick_t                  pick_s;

  // Widen the mask to the full index space and run the shared search
  always_comb begin
    mask_ext_s                  = {MAX_PORTS_C{1'b0}};
    mask_ext_s[NUM_PORTS-1:0]   = mask;
    pick_s                      = rr_pick(mask_ext_s, ptr);
    found                       = pick_s.found;
    idx                         = pick_s.idx;
    for (int i = 0; i < NUM_PORTS; i++) begin
      grant[i] = pick_s.found && (pick_s.idx == i[PORT_IDX_BITS_C-1:0]);
    end
  end

endmodule

// File: rtl/freespace_credit_arbiter.sv
// Queues per-port freespace requests and injects each port's credit packet
// into the leaf output stream, one port at a time in round-robin order.
module freespace_credit_arbiter
  import freespace_credit_arbiter_pkg::*;
#(
  parameter int PACKET_BITS   = PACKET_BITS_C,
  parameter int NUM_IN_PORTS  = 7,
  parameter int PORT_IDX_BITS = PORT_IDX_BITS_C,
  parameter int CNT_BITS      = 4,
  parameter int STALL_LIMIT   = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_IN_PORTS-1:0]             freespace_update,
  input  logic [PACKET_BITS*NUM_IN_PORTS-1:0] packet_from_input_ports,
  output logic [PACKET_BITS-1:0]              pkt_out,
  output logic                                pkt_out_vld,
  input  logic                                pkt_out_rdy,
  output logic [PORT_IDX_BITS-1:0]            grant_idx,
  output logic [NUM_IN_PORTS-1:0]             pending,
  output logic [NUM_IN_PORTS-1:0]             overflow,
  output logic                                stall_condition
);

  localparam int STALL_BITS = $clog2(STALL_LIMIT + 1);
  localparam logic [CNT_BITS-1:0]   CNT_MAX_C   = {CNT_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0]   CNT_ONE_C   = CNT_BITS'(1);
  localparam logic [STALL_BITS-1:0] STALL_MAX_C = STALL_BITS'(STALL_LIMIT);
  localparam logic [PORT_IDX_BITS_C-1:0] LAST_PORT_C = PORT_IDX_BITS_C'(NUM_IN_PORTS - 1);

  logic [CNT_BITS-1:0]        cnt_r     [NUM_IN_PORTS];
  logic [CNT_BITS-1:0]        cnt_nxt_s [NUM_IN_PORTS];
  logic [NUM_IN_PORTS-1:0]    dec_s;
  logic [NUM_IN_PORTS-1:0]    elig_s;
  logic [NUM_IN_PORTS-1:0]    ovf_set_s;
  logic [NUM_IN_PORTS-1:0]    nonzero_nxt_s;
  logic [NUM_IN_PORTS-1:0]    pending_r;
  logic [NUM_IN_PORTS-1:0]    overflow_r;
  logic                       hs_s;

  state_t                     state_r;
  logic [PACKET_BITS-1:0]     pkt_out_r;
  logic                       pkt_out_vld_r;
  logic [PORT_IDX_BITS-1:0]   grant_idx_r;
  logic [PORT_IDX_BITS_C-1:0] rr_ptr_r;
  logic [PORT_IDX_BITS_C-1:0] rr_ptr_nxt_s;

  logic                       arb_found_s;
  logic [PORT_IDX_BITS_C-1:0] arb_idx_s;
  logic [NUM_IN_PORTS-1:0]    arb_grant_s;
  logic [PORT_IDX_BITS-1:0]   winner_idx_s;
  logic [PACKET_BITS-1:0]     winner_pkt_s;

  logic [STALL_BITS-1:0]      stall_cnt_r;
  logic [STALL_BITS-1:0]      stall_nxt_s;
  logic                       stall_condition_r;

  // Per-port next count; a port is eligible only if it still has a request after this cycle's service
  always_comb begin
    hs_s = pkt_out_vld_r & pkt_out_rdy;
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      dec_s[i]     = hs_s && (grant_idx_r == PORT_IDX_BITS'(i));
      elig_s[i]    = (cnt_r[i] != {CNT_BITS{1'b0}}) && !(dec_s[i] && (cnt_r[i] == CNT_ONE_C));
      ovf_set_s[i] = 1'b0;
      cnt_nxt_s[i] = cnt_r[i];
      case ({freespace_update[i], dec_s[i]})
        2'b10: begin
          if (cnt_r[i] == CNT_MAX_C) begin
            ovf_set_s[i] = 1'b1;
          end else begin
            cnt_nxt_s[i] = cnt_r[i] + CNT_ONE_C;
          end
        end
        2'b01:   cnt_nxt_s[i] = cnt_r[i] - CNT_ONE_C;
        default: cnt_nxt_s[i] = cnt_r[i];
      endcase
      nonzero_nxt_s[i] = (cnt_nxt_s[i] != {CNT_BITS{1'b0}});
    end
  end

  rr_arbiter #(
    .NUM_PORTS (NUM_IN_PORTS)
  ) u_rr_arbiter (
    .mask  (elig_s),
    .ptr   (rr_ptr_r),
    .found (arb_found_s),
    .idx   (arb_idx_s),
    .grant (arb_grant_s)
  );

  // Winner's packet slice, its index and the pointer just past it
  always_comb begin
    winner_idx_s = PORT_IDX_BITS'(arb_idx_s);
    rr_ptr_nxt_s = (arb_idx_s == LAST_PORT_C) ? {PORT_IDX_BITS_C{1'b0}}
                                              : arb_idx_s + PORT_IDX_BITS_C'(1);
    winner_pkt_s = {PACKET_BITS{1'b0}};
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      if (arb_grant_s[i]) begin
        winner_pkt_s = packet_from_input_ports[i*PACKET_BITS +: PACKET_BITS];
      end else begin
        winner_pkt_s = winner_pkt_s;
      end
    end
  end

  // Request counters, sticky overflow flags and the pending copy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_IN_PORTS; i++) begin
        cnt_r[i] <= {CNT_BITS{1'b0}};
      end
      overflow_r <= {NUM_IN_PORTS{1'b0}};
      pending_r  <= {NUM_IN_PORTS{1'b0}};
    end else begin
      for (int i = 0; i < NUM_IN_PORTS; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
      overflow_r <= overflow_r | ovf_set_s;
      pending_r  <= nonzero_nxt_s;
    end
  end

  // Output FSM: load a winner when idle or right on a handshake, freeze while back-pressured
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      pkt_out_r     <= {PACKET_BITS{1'b0}};
      pkt_out_vld_r <= 1'b0;
      grant_idx_r   <= {PORT_IDX_BITS{1'b0}};
      rr_ptr_r      <= {PORT_IDX_BITS_C{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (arb_found_s) begin
            pkt_out_r     <= winner_pkt_s;
            grant_idx_r   <= winner_idx_s;
            pkt_out_vld_r <= 1'b1;
            rr_ptr_r      <= rr_ptr_nxt_s;
            state_r       <= ST_SEND;
          end else begin
            pkt_out_vld_r <= 1'b0;
            state_r       <= ST_IDLE;
          end
        end
        ST_SEND: begin
          if (hs_s && arb_found_s) begin
            pkt_out_r     <= winner_pkt_s;
            grant_idx_r   <= winner_idx_s;
            pkt_out_vld_r <= 1'b1;
            rr_ptr_r      <= rr_ptr_nxt_s;
            state_r       <= ST_SEND;
          end else if (hs_s) begin
            pkt_out_vld_r <= 1'b0;
            state_r       <= ST_IDLE;
          end else begin
            state_r       <= ST_SEND;
          end
        end
        default: begin
          pkt_out_vld_r <= 1'b0;
          state_r       <= ST_IDLE;
        end
      endcase
    end
  end

  // Saturating count of consecutive back-pressured cycles
  always_comb begin
    if (pkt_out_vld_r && !pkt_out_rdy) begin
      if (stall_cnt_r == STALL_MAX_C) begin
        stall_nxt_s = stall_cnt_r;
      end else begin
        stall_nxt_s = stall_cnt_r + STALL_BITS'(1);
      end
    end else begin
      stall_nxt_s = {STALL_BITS{1'b0}};
    end
  end

  // Stall counter and its registered flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r       <= {STALL_BITS{1'b0}};
      stall_condition_r <= 1'b0;
    end else begin
      stall_cnt_r       <= stall_nxt_s;
      stall_condition_r <= (stall_nxt_s == STALL_MAX_C);
    end
  end

  assign pkt_out         = pkt_out_r;
  assign pkt_out_vld     = pkt_out_vld_r;
  assign grant_idx       = grant_idx_r;
  assign pending         = pending_r;
  assign overflow        = overflow_r;
  assign stall_condition = stall_condition_r;

endmodule

// File: tb/tb_freespace_credit_arbiter.sv
// Randomised and directed bench for freespace_credit_arbiter against a queue-count
// reference model, plus literal expectations for the directed scenarios.
module tb_freespace_credit_arbiter;

  localparam int PB = 97;
  localparam int NP = 7;
  localparam int IB = 3;
  localparam int CB = 4;
  localparam int SL = 16;
  localparam int CMAX = 15;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [NP-1:0]    freespace_update = '0;
  logic [PB*NP-1:0] packet_from_input_ports = '0;
  logic             pkt_out_rdy = 1'b1;
  logic [PB-1:0]    pkt_out;
  logic             pkt_out_vld;
  logic [IB-1:0]    grant_idx;
  logic [NP-1:0]    pending;
  logic [NP-1:0]    overflow;
  logic             stall_condition;

  always #5 clk = ~clk;

  freespace_credit_arbiter #(
    .PACKET_BITS (PB), .NUM_IN_PORTS (NP), .PORT_IDX_BITS (IB),
    .CNT_BITS (CB), .STALL_LIMIT (SL)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .freespace_update        (freespace_update),
    .packet_from_input_ports (packet_from_input_ports),
    .pkt_out                 (pkt_out),
    .pkt_out_vld             (pkt_out_vld),
    .pkt_out_rdy             (pkt_out_rdy),
    .grant_idx               (grant_idx),
    .pending                 (pending),
    .overflow                (overflow),
    .stall_condition         (stall_condition)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: queued request count per port, the packet currently offered,
  // the round-robin start position and the length of the current stall.
  int            m_cnt [NP];
  bit            m_ovf [NP];
  bit            m_vld = 1'b0;
  int            m_idx = 0;
  logic [PB-1:0] m_pkt = '0;
  int            m_ptr = 0;
  int            m_stall = 0;

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_cnt[i] = 0;
      m_ovf[i] = 1'b0;
    end
    m_vld = 1'b0; m_idx = 0; m_pkt = '0; m_ptr = 0; m_stall = 0;
  endtask

  task automatic model_step();
    bit served;
    bit found;
    int w;
    int left [NP];
    served = m_vld && pkt_out_rdy;
    for (int i = 0; i < NP; i++) left[i] = m_cnt[i] - ((served && m_idx == i) ? 1 : 0);
    found = 1'b0;
    w = 0;
    for (int k = 0; k < NP; k++) begin
      if (!found && left[(m_ptr + k) % NP] > 0) begin
        found = 1'b1;
        w = (m_ptr + k) % NP;
      end
    end
    if (m_vld && !pkt_out_rdy) m_stall = (m_stall < SL) ? m_stall + 1 : SL;
    else m_stall = 0;
    for (int i = 0; i < NP; i++) begin
      m_cnt[i] = left[i];
      if (freespace_update[i]) begin
        if (left[i] == CMAX) m_ovf[i] = 1'b1;
        else m_cnt[i] = left[i] + 1;
      end
    end
    if (!m_vld || served) begin
      if (found) begin
        m_vld = 1'b1;
        m_idx = w;
        m_pkt = packet_from_input_ports[w*PB +: PB];
        m_ptr = (w + 1) % NP;
      end else begin
        m_vld = 1'b0;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else model_step();
    end
  end

  // Every-cycle comparison of all outputs against the model
  initial begin : cmp
    logic [NP-1:0] pm;
    logic [NP-1:0] om;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NP; i++) begin
        pm[i] = (m_cnt[i] != 0);
        om[i] = m_ovf[i];
      end
      check("model_vld", pkt_out_vld, m_vld);
      if (m_vld) begin
        check("model_grant", grant_idx, m_idx);
        check("model_pkt", pkt_out, m_pkt);
      end
      check("model_pending", pending, pm);
      check("model_overflow", overflow, om);
      check("model_stall", stall_condition, (m_stall == SL));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_slice(input int p, input logic [PB-1:0] v);
    packet_from_input_ports[p*PB +: PB] = v;
  endtask

  task automatic pulse(input logic [NP-1:0] m);
    freespace_update = m;
    tick();
    freespace_update = '0;
  endtask

  logic [PB-1:0] bp_slice;
  int            n2;
  int            nv;

  initial begin
    reset = 1'b0;
    pkt_out_rdy = 1'b1;
    repeat (3) tick();
    reset = 1'b1;

    // Idle after reset
    repeat (20) tick();
    check("idle_vld", pkt_out_vld, 1'b0);
    check("idle_pending", pending, 7'b0);
    check("idle_stall", stall_condition, 1'b0);

    // Single request on port 3: valid two cycles after the pulse, gone one cycle later
    set_slice(3, 97'h1_0000_0003);
    pulse(7'b0001000);
    check("single_pending", pending, 7'b0001000);
    check("single_vld_early", pkt_out_vld, 1'b0);
    tick();
    check("single_vld", pkt_out_vld, 1'b1);
    check("single_pkt", pkt_out, 97'h1_0000_0003);
    check("single_grant", grant_idx, 3'd3);
    tick();
    check("single_done", pkt_out_vld, 1'b0);

    // Simultaneous pulses with the pointer at 4: order 6, 0, 3 back to back
    set_slice(0, 97'h0AA);
    set_slice(6, 97'h066);
    pulse(7'b1001001);
    tick();
    check("rr_g6", grant_idx, 3'd6);
    check("rr_p6", pkt_out, 97'h066);
    tick();
    check("rr_g0", grant_idx, 3'd0);
    check("rr_v0", pkt_out_vld, 1'b1);
    tick();
    check("rr_g3", grant_idx, 3'd3);
    check("rr_v3", pkt_out_vld, 1'b1);
    tick();
    check("rr_end_vld", pkt_out_vld, 1'b0);
    check("rr_end_pending", pending, 7'b0);

    // Back-pressure on port 1
    bp_slice = 97'h1_2345_6789_ABCD;
    set_slice(1, bp_slice);
    pkt_out_rdy = 1'b0;
    pulse(7'b0000010);
    tick();
    check("bp_vld", pkt_out_vld, 1'b1);
    check("bp_grant", grant_idx, 3'd1);
    for (int k = 1; k <= 20; k++) begin
      tick();
      check("bp_pkt", pkt_out, bp_slice);
      check("bp_stall", stall_condition, (k >= SL));
    end
    pkt_out_rdy = 1'b1;
    tick();
    check("bp_release_vld", pkt_out_vld, 1'b0);
    check("bp_release_stall", stall_condition, 1'b0);

    // Saturation on port 2: 17 pulses while blocked, 15 packets afterwards
    set_slice(2, 97'h222);
    pkt_out_rdy = 1'b0;
    freespace_update = 7'b0000100;
    repeat (17) tick();
    freespace_update = '0;
    check("sat_overflow", overflow, 7'b0000100);
    check("sat_pending", pending, 7'b0000100);
    pkt_out_rdy = 1'b1;
    n2 = 0;
    for (int c = 0; c < 40 && pkt_out_vld; c++) begin
      if (grant_idx == 3'd2) n2++;
      tick();
    end
    check("sat_count", n2, 15);
    check("sat_drained", pkt_out_vld, 1'b0);
    check("sat_sticky", overflow, 7'b0000100);

    // Asynchronous reset while sending with three requests queued
    pkt_out_rdy = 1'b0;
    pulse(7'b0110010);
    tick();
    check("mid_vld", pkt_out_vld, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_vld", pkt_out_vld, 1'b0);
    check("mid_rst_pending", pending, 7'b0);
    check("mid_rst_overflow", overflow, 7'b0);
    tick();
    tick();
    reset = 1'b1;
    pkt_out_rdy = 1'b1;
    nv = 0;
    repeat (10) begin
      tick();
      if (pkt_out_vld) nv++;
    end
    check("mid_rst_no_pkts", nv, 0);

    // Random traffic with periodic back-pressure windows
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 64 == 0) begin
        for (int p = 0; p < NP; p++) set_slice(p, {$urandom, $urandom, $urandom, $urandom});
      end
      freespace_update = NP'($urandom & $urandom);
      pkt_out_rdy = (cyc % 300 < 40) ? 1'b0 : ($urandom_range(0, 3) != 0);
      tick();
    end
    freespace_update = '0;
    pkt_out_rdy = 1'b1;
    for (int c = 0; c < 300 && (pkt_out_vld || pending != '0); c++) tick();
    check("drain_vld", pkt_out_vld, 1'b0);
    check("drain_pending", pending, 7'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
